// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES inverse cipher.
package aes_pkg;

  typedef logic [15:0][7:0] aes_block_t;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = gf_xtime(x);
    end
    return p;
  endfunction

  // Row r of the 4x4 state (bytes r, r+4, r+8, r+12) rotates right by r.
  function automatic aes_block_t inv_shift_rows(input aes_block_t s);
    aes_block_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
      end
    end
    return o;
  endfunction

  function automatic aes_block_t inv_mix_columns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c + 1];
      a2 = s[4*c + 2];
      a3 = s[4*c + 3];
      o[4*c]     = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[4*c + 1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[4*c + 2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[4*c + 3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = INV_SBOX[byte_i];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
// Round keys are fetched combinationally from an external store via key_idx.
// Optional build macro AES_INV_SBOX_BYPASS_EN adds isb_bypass, which replaces
// InvSubBytes by the identity for a whole block (captured at acceptance).
//
// state    | meaning
// ST_IDLE  | waiting for a ciphertext block, key_idx = NR
// ST_ROUND | one inverse round per edge, key_idx = round counter
// ST_DONE  | plaintext presented until out_ready
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
`ifdef AES_INV_SBOX_BYPASS_EN
  input  logic             isb_bypass,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][7:0] cipher_in,
  output logic [3:0]       key_idx,
  input  logic [15:0][7:0] round_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] plain_out
);

  if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam logic [3:0] NR_M1  = 4'(NR - 1);

  aes_state_e fsm_q, fsm_d;
  aes_block_t state_q, state_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       sb_bypass;

  aes_block_t isr, sb_out, sub, ark, rnd;

`ifdef AES_INV_SBOX_BYPASS_EN
  logic byp_q, byp_d;

  // Bypass mode is latched with the block so it cannot change mid-decryption.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byp_q <= 1'b0;
    else        byp_q <= byp_d;
  end

  assign sb_bypass = byp_q;
`else
  assign sb_bypass = 1'b0;
`endif

  assign isr = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .byte_i (isr[i]),
      .byte_o (sb_out[i])
    );
  end

  assign sub = sb_bypass ? isr : sb_out;
  assign ark = sub ^ round_key;
  // The last round (counter at zero) skips InvMixColumns.
  assign rnd = (rcnt_q == 4'd0) ? ark : inv_mix_columns(ark);

  assign key_idx = (fsm_q == ST_ROUND) ? rcnt_q : NR_IDX;

  // State, round counter and FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rcnt_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    plain_out = '0;
`ifdef AES_INV_SBOX_BYPASS_EN
    byp_d     = byp_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = cipher_in ^ round_key;
          rcnt_d  = NR_M1;
          fsm_d   = ST_ROUND;
`ifdef AES_INV_SBOX_BYPASS_EN
          byp_d   = isb_bypass;
`endif
        end
      end
      ST_ROUND: begin
        state_d = rnd;
        if (rcnt_q == 4'd0) fsm_d  = ST_DONE;
        else                rcnt_d = rcnt_q - 4'd1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        plain_out = state_q;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench for aes_inv_cipher_iter: FIPS-197 vectors, S-box corners,
// randomized blocks against a behavioural inverse-cipher model, back-pressure,
// asynchronous reset and an NR=14 instance.
module tb_aes_inv_cipher_iter;
  import aes_pkg::*;

  localparam int NRA = 10;
  localparam int NRB = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [3:0] key_idx;
  logic [15:0][7:0] cipher_in, round_key, plain_out;
  logic in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [3:0] key_idx_b;
  logic [15:0][7:0] cipher_in_b, round_key_b, plain_out_b;
`ifdef AES_INV_SBOX_BYPASS_EN
  logic isb_bypass;
`endif

  bit [127:0] rk_a [0:15];
  bit [127:0] rk_b [0:15];
  bit [127:0] ks   [0:15];
  bit [7:0]   isbox_m [256];
  bit [7:0]   sbox_m  [256];
  int checks = 0;
  int errors = 0;

  assign round_key   = rk_a[key_idx];
  assign round_key_b = rk_b[key_idx_b];

  aes_inv_cipher_iter #(.NR(NRA)) u_dut_a (
`ifdef AES_INV_SBOX_BYPASS_EN
    .isb_bypass (isb_bypass),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher_in (cipher_in),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain_out (plain_out)
  );

  aes_inv_cipher_iter #(.NR(NRB)) u_dut_b (
`ifdef AES_INV_SBOX_BYPASS_EN
    .isb_bypass (1'b0),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .cipher_in (cipher_in_b),
    .key_idx   (key_idx_b),
    .round_key (round_key_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .plain_out (plain_out_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit [7:0] gmul(bit [7:0] a, bit [7:0] b);
    bit [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic bit [7:0] rotl8(bit [7:0] b, int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from field inverse plus affine map; inverse table derived from it.
  task automatic build_sbox();
    bit [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[x]  = s;
      isbox_m[s] = 8'(x);
    end
  endtask

  // Hex literal written in FIPS order (first byte leftmost) -> byte i at bits [8i+:8].
  function automatic bit [127:0] fips(bit [127:0] h);
    bit [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = h[127 - 8*i -: 8];
    return o;
  endfunction

  function automatic bit [31:0] subw(bit [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // FIPS-197 key expansion; key bytes left-aligned in a 256-bit vector.
  task automatic expand_key(input bit [255:0] key, input int nk, input int nr);
    bit [31:0] w [0:59];
    bit [31:0] t;
    bit [7:0]  rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int k = 0; k < 16; k++) ks[k] = '0;
    for (int k = 0; k <= nr; k++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          ks[k][8*(4*c + r) +: 8] = w[4*k + c][31 - 8*r -: 8];
  endtask

  function automatic bit [127:0] model(bit [127:0] ct, int nr, bit byp, bit use_b);
    bit [7:0]   s [4][4];
    bit [7:0]   t [4][4];
    bit [7:0]   mc [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    bit [127:0] kb, res;
    kb = use_b ? rk_b[nr] : rk_a[nr];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = ct[8*(r + 4*c) +: 8] ^ kb[8*(r + 4*c) +: 8];
    for (int k = nr - 1; k >= 0; k--) begin
      kb = use_b ? rk_b[k] : rk_a[k];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          t[r][c] = s[r][(c - r + 4) % 4];
          if (!byp) t[r][c] = isbox_m[t[r][c]];
          t[r][c] ^= kb[8*(r + 4*c) +: 8];
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (k == 0) s[r][c] = t[r][c];
          else begin
            s[r][c] = 0;
            for (int j = 0; j < 4; j++) s[r][c] ^= gmul(mc[(j - r + 4) % 4], t[j][c]);
          end
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[8*(r + 4*c) +: 8] = s[r][c];
    return res;
  endfunction

  function automatic bit [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One block through the NR=10 instance: key_idx trace, latency, hold in DONE, release.
  task automatic run_a(input bit [127:0] ct, input bit [127:0] exp, input int hold,
                       input bit byp, input string tag);
    int n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, ":in_ready"}, in_ready, 1);
    check({tag, ":key_idx_idle"}, key_idx, NRA);
`ifdef AES_INV_SBOX_BYPASS_EN
    isb_bypass = byp;
`endif
    in_valid  = 1'b1;
    cipher_in = ct;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    cipher_in = rand128();
`ifdef AES_INV_SBOX_BYPASS_EN
    isb_bypass = ~byp;
`endif
    n = 1;
    while (!out_valid && n < 40) begin
      check({tag, ":key_idx"}, key_idx, 128'(NRA - n));
      check({tag, ":busy"}, in_ready, 0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, ":latency"}, n, NRA + 1);
    for (int h = 0; h < hold; h++) begin
      check({tag, ":hold_data"}, plain_out, exp);
      check({tag, ":hold_ready"}, in_ready, 0);
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, out_valid, 1);
    end
    check({tag, ":plain"}, plain_out, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":released"}, out_valid, 0);
    check({tag, ":idle"}, in_ready, 1);
  endtask

  initial begin
    bit [127:0] ct_a, ct_b, exp_a;
    int n;
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; cipher_in = '0;
    in_valid_b = 0; out_ready_b = 0; cipher_in_b = '0;
`ifdef AES_INV_SBOX_BYPASS_EN
    isb_bypass = 1'b0;
`endif
    for (int k = 0; k < 16; k++) begin rk_a[k] = '0; rk_b[k] = '0; end
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check("rst:out_valid", out_valid, 0);
    check("rst:in_ready", in_ready, 1);
    check("rst:key_idx", key_idx, NRA);
    check("rst:plain_out", plain_out, 0);
    check("rst:key_idx_b", key_idx_b, NRB);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("ordy_idle:no_valid", out_valid, 0);
    out_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NRA);
    for (int k = 0; k < 16; k++) rk_a[k] = ks[k];
    run_a(fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
          fips(128'h00112233445566778899aabbccddeeff), 0, 0, "c1");

    // S-box corners with all-zero keys
    for (int k = 0; k < 16; k++) rk_a[k] = '0;
    run_a({16{8'h63}}, model({16{8'h63}}, NRA, 0, 0), 1, 0, "sb63");
    run_a({16{8'h00}}, model({16{8'h00}}, NRA, 0, 0), 0, 0, "sb00");

    // Randomized keys and blocks
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k <= NRA; k++) rk_a[k] = rand128();
      ct_a = rand128();
      run_a(ct_a, model(ct_a, NRA, 0, 0), $urandom_range(0, 3), 0, "rnd");
    end

    // Back-pressure with a second block waiting
    ct_a = rand128();
    ct_b = rand128();
    exp_a = model(ct_a, NRA, 0, 0);
    in_valid = 1'b1; cipher_in = ct_a;
    @(posedge clk); #1;
    cipher_in = ct_b;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("bp:valid", out_valid, 1);
    for (int h = 0; h < 5; h++) begin
      check("bp:data", plain_out, exp_a);
      check("bp:in_ready", in_ready, 0);
      @(posedge clk); #1;
      check("bp:valid_hold", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp:not_accepted", in_ready, 1);
    check("bp:idle_key", key_idx, NRA);
    check("bp:released", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp:accepted", in_ready, 0);
    check("bp:first_round", key_idx, NRA - 1);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("bp:second", plain_out, model(ct_b, NRA, 0, 0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset at round 4
    ct_a = rand128();
    in_valid = 1'b1; cipher_in = ct_a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid:out_valid", out_valid, 0);
    check("rst_mid:plain", plain_out, 0);
    check("rst_mid:in_ready", in_ready, 1);
    check("rst_mid:key_idx", key_idx, NRA);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid:no_valid", out_valid, 0);

    // Reset while a result is waiting
    in_valid = 1'b1; cipher_in = ct_a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("rst_done:valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_done:out_valid", out_valid, 0);
    check("rst_done:plain", plain_out, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ct_a = rand128();
    run_a(ct_a, model(ct_a, NRA, 0, 0), 2, 0, "rst_rec");

    // NR=14, FIPS-197 C.3
    expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NRB);
    for (int k = 0; k < 16; k++) rk_b[k] = ks[k];
    check("c3:in_ready", in_ready_b, 1);
    in_valid_b = 1'b1;
    cipher_in_b = fips(128'h8ea2b7ca516745bfeafc49904b496089);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    cipher_in_b = '0;
    n = 1;
    while (!out_valid_b && n < 40) begin
      check("c3:key_idx", key_idx_b, 128'(NRB - n));
      @(posedge clk); #1;
      n++;
    end
    check("c3:latency", n, NRB + 1);
    check("c3:plain", plain_out_b, fips(128'h00112233445566778899aabbccddeeff));
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    check("c3:released", out_valid_b, 0);

`ifdef AES_INV_SBOX_BYPASS_EN
    for (int k = 0; k < 16; k++) rk_a[k] = '0;
    for (int i = 0; i < 16; i++) ct_a[8*i +: 8] = 8'(i);
    run_a(ct_a, model(ct_a, NRA, 1, 0), 0, 1, "byp1");
    run_a(ct_a, model(ct_a, NRA, 0, 0), 0, 0, "byp0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
